bus_scheduler: RTL and testbench

Cycle-level scheduler for the shared system bus (SRAM, I/O, address/data lines), clocked from the 16 MHz master clock. It divides each 1 µs CPU cycle into 16 phases and assigns fixed slots to video fetch, Raspberry Pi access and the 6502. It generates `phi2`, `clk8` and all select/strobe qualifiers that top-level decoding uses to steer `bus_addr`, `bus_data`, `ram_*` and the I/O chip selects. It also runs the four-phase `pi_pending`/`pi_done` handshake with the asynchronous Pi.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/pi_handshake.sv | 72 +++++++
 rtl/bus_scheduler.sv | 93 +++++++++
 tb/tb_bus_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Purpose  : Slot boundary phases and Pi handshake state type for the
//             16-phase shared-bus schedule.
//  Revision : 1.0  initial release
// ============================================================================
package bus_pkg;

    localparam logic [3:0] PH_VIDEO_RAM  = 4'd1;
    localparam logic [3:0] PH_VIDEO_ROM  = 4'd3;
    localparam logic [3:0] PH_PI_GRANT   = 4'd3;
    localparam logic [3:0] PH_PI_FIRST   = 4'd4;
    localparam logic [3:0] PH_PI_LAST    = 4'd7;
    localparam logic [3:0] PH_CPU_FIRST  = 4'd8;
    localparam logic [3:0] PH_IO_FIRST   = 4'd10;
    localparam logic [3:0] PH_PHI2_FIRST = 4'd12;

    typedef enum logic [1:0] {PI_IDLE, PI_GRANT, PI_DONE} pi_state_t;

endpackage
`default_nettype wire

// File: rtl/pi_handshake.sv
`default_nettype none
// ============================================================================
//  Module   : pi_handshake
//  Purpose  : pi_pending synchronizer and four-phase request/done FSM that
//             owns the Pi slot (phases 4-7).
//  Revision : 1.0  initial release
// ============================================================================
module pi_handshake
    import bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk16,
    input  logic       reset,
    input  logic [3:0] phase,
    input  logic       pi_pending,
    output logic       pi_select,
    output logic       pi_strobe,
    output logic       pi_done
);

    localparam logic [3:0] c_ph_strobe_first = PH_PI_FIRST + 4'd1;
    localparam logic [3:0] c_ph_strobe_last  = PH_PI_LAST - 4'd1;

    logic [SYNC_STAGES-1:0] r_sync;
    pi_state_t              r_state;
    pi_state_t              w_state_next;
    logic                   w_pending;
    logic [3:0]             w_phase_next;
    logic                   r_pi_select;
    logic                   r_pi_strobe;
    logic                   r_pi_done;

    assign w_pending    = r_sync[SYNC_STAGES-1];
    assign w_phase_next = phase + 4'd1;

    // A request is only granted once the previous done has been acknowledged
    // by pending falling, so each rising edge of pending yields one transfer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PI_IDLE:  if (phase == PH_PI_GRANT && w_pending && !r_pi_done) w_state_next = PI_GRANT;
            PI_GRANT: if (phase == PH_PI_LAST) w_state_next = PI_DONE;
            PI_DONE:  if (!w_pending) w_state_next = PI_IDLE;
            default:  w_state_next = PI_IDLE;
        endcase
    end

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            r_sync      <= '0;
            r_state     <= PI_IDLE;
            r_pi_select <= 1'b0;
            r_pi_strobe <= 1'b0;
            r_pi_done   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], pi_pending};
            r_state     <= w_state_next;
            r_pi_select <= (w_state_next == PI_GRANT);
            r_pi_strobe <= (w_state_next == PI_GRANT)
                           && (w_phase_next >= c_ph_strobe_first)
                           && (w_phase_next <= c_ph_strobe_last);
            r_pi_done   <= (w_state_next == PI_DONE);
        end
    end

    assign pi_select = r_pi_select;
    assign pi_strobe = r_pi_strobe;
    assign pi_done   = r_pi_done;

endmodule
`default_nettype wire

// File: rtl/bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bus_scheduler
//  Purpose  : 16-phase shared-bus scheduler: phase counter, video/CPU slot
//             decode and the Pi handshake slot.
//  Revision : 1.0  initial release
// ============================================================================
module bus_scheduler
    import bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk16,
    input  logic       reset,
    input  logic       pi_pending,
    input  logic       video_enable,
    output logic [3:0] phase,
    output logic       clk8,
    output logic       video_select,
    output logic       video_ram_strobe,
    output logic       video_rom_strobe,
    output logic       pi_select,
    output logic       pi_strobe,
    output logic       pi_done,
    output logic       cpu_select,
    output logic       io_select,
    output logic       cpu_strobe
);

    localparam logic [3:0] c_ph_wrap = 4'hF;

    logic [3:0] r_phase;
    logic [3:0] w_phase_next;
    logic       r_video_en;
    logic       w_video_en;
    logic       r_video_select;
    logic       r_video_ram_strobe;
    logic       r_video_rom_strobe;
    logic       r_cpu_select;
    logic       r_io_select;
    logic       r_cpu_strobe;

    assign w_phase_next = r_phase + 4'd1;
    // Enable is captured at phase 15 and frozen for the whole video slot.
    assign w_video_en   = (r_phase == c_ph_wrap) ? video_enable : r_video_en;

    // Slot qualifiers are decoded from the next phase so they line up with
    // the counter while still coming straight out of flops.
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            r_phase            <= 4'd0;
            r_video_en         <= 1'b0;
            r_video_select     <= 1'b0;
            r_video_ram_strobe <= 1'b0;
            r_video_rom_strobe <= 1'b0;
            r_cpu_select       <= 1'b0;
            r_io_select        <= 1'b0;
            r_cpu_strobe       <= 1'b0;
        end else begin
            r_phase            <= w_phase_next;
            r_video_en         <= w_video_en;
            r_video_select     <= w_video_en && (w_phase_next < PH_PI_FIRST);
            r_video_ram_strobe <= w_video_en && (w_phase_next == PH_VIDEO_RAM);
            r_video_rom_strobe <= w_video_en && (w_phase_next == PH_VIDEO_ROM);
            r_cpu_select       <= (w_phase_next >= PH_CPU_FIRST);
            r_io_select        <= (w_phase_next >= PH_IO_FIRST);
            r_cpu_strobe       <= (w_phase_next >= PH_PHI2_FIRST);
        end
    end

    pi_handshake #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pi_handshake (
        .clk16      (clk16),
        .reset      (reset),
        .phase      (r_phase),
        .pi_pending (pi_pending),
        .pi_select  (pi_select),
        .pi_strobe  (pi_strobe),
        .pi_done    (pi_done)
    );

    assign phase            = r_phase;
    assign clk8             = r_phase[0];
    assign video_select     = r_video_select;
    assign video_ram_strobe = r_video_ram_strobe;
    assign video_rom_strobe = r_video_rom_strobe;
    assign cpu_select       = r_cpu_select;
    assign io_select        = r_io_select;
    assign cpu_strobe       = r_cpu_strobe;

endmodule
`default_nettype wire

// File: tb/tb_bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_scheduler
//  Purpose  : Directed self-checking bench for bus_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_scheduler;

    logic       clk16 = 1'b0;
    logic       reset = 1'b1;
    logic       pi_pending = 1'b0;
    logic       video_enable = 1'b1;
    logic [3:0] phase;
    logic       clk8;
    logic       video_select;
    logic       video_ram_strobe;
    logic       video_rom_strobe;
    logic       pi_select;
    logic       pi_strobe;
    logic       pi_done;
    logic       cpu_select;
    logic       io_select;
    logic       cpu_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] w_outs;
    assign w_outs = {phase, clk8, video_select, video_ram_strobe, video_rom_strobe,
                     pi_select, pi_strobe, pi_done, cpu_select, io_select, cpu_strobe};

    bus_scheduler #(
        .SYNC_STAGES (2)
    ) dut (
        .clk16            (clk16),
        .reset            (reset),
        .pi_pending       (pi_pending),
        .video_enable     (video_enable),
        .phase            (phase),
        .clk8             (clk8),
        .video_select     (video_select),
        .video_ram_strobe (video_ram_strobe),
        .video_rom_strobe (video_rom_strobe),
        .pi_select        (pi_select),
        .pi_strobe        (pi_strobe),
        .pi_done          (pi_done),
        .cpu_select       (cpu_select),
        .io_select        (io_select),
        .cpu_strobe       (cpu_strobe)
    );

    always #5 clk16 = ~clk16;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advances at least one clock, then up to 40 more until phase == p.
    task automatic wait_phase(input logic [3:0] p);
        int n = 0;
        @(negedge clk16);
        while (phase != p && n < 40) begin
            @(negedge clk16);
            n++;
        end
        if (phase != p) chk("wait_phase", 16'(phase), 16'(p));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk16);
            n++;
            if (pi_done) break;
        end
    endtask

    // Only one bus owner at a time, every cycle out of reset.
    always @(negedge clk16) begin
        if (!reset)
            chk("excl", 16'($countones({video_select, pi_select, cpu_select}) <= 1), 16'd1);
    end

    initial begin
        logic [3:0] ph;
        int         n;
        int         grants;

        // Reset state
        repeat (2) @(negedge clk16);
        chk("rst_outs", 16'(w_outs), 16'd0);
        reset = 1'b0;
        // Free-running count and slot decode, two full cycles
        for (int i = 0; i < 32; i++) begin
            ph = 4'(i);
            if (i > 0) @(negedge clk16);
            chk("cnt_phase", 16'({phase, clk8}), 16'({ph, ph[0]}));
            chk("cpu_slot", 16'({cpu_select, io_select, cpu_strobe}),
                16'({ph >= 4'd8, ph >= 4'd10, ph >= 4'd12}));
            chk("pi_idle", 16'({pi_select, pi_strobe, pi_done}), 16'd0);
            if (i >= 16)
                chk("video", 16'({video_select, video_ram_strobe, video_rom_strobe}),
                    16'({ph < 4'd4, ph == 4'd1, ph == 4'd3}));
        end

        // Request at phase 1: granted in the same cycle
        wait_phase(4'd1);
        pi_pending = 1'b1;
        for (int k = 2; k < 16; k++) begin
            ph = 4'(k);
            @(negedge clk16);
            chk("early_grant", 16'({phase, pi_select, pi_strobe, pi_done}),
                16'({ph, ph >= 4'd4 && ph <= 4'd7, ph == 4'd5 || ph == 4'd6, ph >= 4'd8}));
        end
        pi_pending = 1'b0;
        @(negedge clk16);
        chk("done_hold1", 16'(pi_done), 16'd1);
        @(negedge clk16);
        chk("done_hold2", 16'(pi_done), 16'd1);
        @(negedge clk16);
        chk("done_fall", 16'({pi_done, pi_select}), 16'd0);

        // Request at phase 2: misses this cycle's sync window
        wait_phase(4'd2);
        pi_pending = 1'b1;
        wait_done(n);
        chk("late_lat", 16'(n), 16'd22);
        chk("late_done_ph", 16'(phase), 16'd8);

        // Pending held high: no second grant
        grants = 0;
        repeat (40) begin
            @(negedge clk16);
            if (pi_select) grants++;
        end
        chk("no_regrant", 16'(grants), 16'd0);
        chk("done_held", 16'(pi_done), 16'd1);
        pi_pending = 1'b0;
        repeat (3) @(negedge clk16);
        chk("done_fall2", 16'(pi_done), 16'd0);
        pi_pending = 1'b1;
        wait_done(n);
        chk("regrant", 16'({pi_done, 1'(n <= 34)}), 16'b11);

        // Reset in phase 5 of a grant
        pi_pending = 1'b0;
        repeat (4) @(negedge clk16);
        wait_phase(4'd1);
        pi_pending = 1'b1;
        wait_phase(4'd5);
        chk("grant_ph5", 16'({pi_select, pi_strobe}), 16'b11);
        reset = 1'b1;
        pi_pending = 1'b0;
        #1;
        chk("rst_async", 16'(w_outs), 16'd0);
        repeat (2) @(negedge clk16);
        reset = 1'b0;
        chk("rel_state", 16'({phase, pi_done}), 16'd0);
        wait_phase(4'd1);
        pi_pending = 1'b1;
        wait_done(n);
        chk("rereq_lat", 16'(n), 16'd7);
        pi_pending = 1'b0;

        // Video disabled at phase 15 suppresses the next slot
        wait_phase(4'd14);
        video_enable = 1'b0;
        repeat (5) begin
            @(negedge clk16);
            chk("vid_off", 16'({video_select, video_ram_strobe, video_rom_strobe}), 16'd0);
        end
        video_enable = 1'b1;
        wait_phase(4'd0);
        chk("vid_on_sel", 16'({video_select, video_ram_strobe}), 16'b10);
        wait_phase(4'd1);
        chk("vid_ram", 16'({video_select, video_ram_strobe}), 16'b11);
        video_enable = 1'b0;
        wait_phase(4'd3);
        chk("vid_rom_held", 16'({video_select, video_rom_strobe}), 16'b11);
        video_enable = 1'b1;

        // Random pending traffic; exclusivity monitored every cycle
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk16);
            if ($urandom_range(0, 7) == 0) pi_pending = ~pi_pending;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
